fetch_prefetch: RTL

Instruction prefetch stage sitting directly upstream of the core's decode logic. It replaces the bare PC register of the fetch path. It runs ahead of decode, issuing word-aligned instruction reads over a valid/ready request channel to instruction memory, and buffers in-order responses in a small queue. It delivers instructions, each with its PC, over a valid/ready handshake, and flushes cleanly on a PC redirect from branch/jump resolution.

---
 rtl/rv32_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 82 ++++++++
 rtl/fetch_prefetch.sv | 112 +++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch path.
//   XLEN             : architectural register / address width
//   RESET_PC_DEFAULT : default first fetch address after reset
//   NOP_INSTR        : canonical NOP (addi x0, x0, 0), shown on an empty queue
//   fetch_entry_t    : one buffered instruction together with its PC
//   word_align()     : clears the byte-offset bits of an address
package rv32_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0100_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue for the prefetch stage: synchronous FIFO of
// {instr, pc} entries with flush and an always-registered head.
//   clock        : rising-edge clock
//   reset        : asynchronous active-low reset
//   push_i       : write wdata_i at the tail (ignored when full or flushing)
//   pop_i        : drop the head entry (ignored when empty or flushing)
//   flush_i      : discard all entries
//   wdata_i      : entry to write
//   head_valid_o : queue holds at least one entry
//   head_o       : head entry; {NOP, 0} when empty
//   count_o      : number of buffered entries
module fetch_fifo
  import rv32_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output logic          head_valid_o,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_eff;
  logic          pop_eff;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    push_eff = push_i && (count_q != CW'(DEPTH));
    pop_eff  = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_eff) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_eff)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_eff) - CW'(pop_eff);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible unless count_q says so.
  always_ff @(posedge clock) begin
    if (push_eff && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head is selected purely from registers, so it changes only at clock edges.
  always_comb begin
    head_valid_o = (count_q != '0);
    head_o.instr = NOP_INSTR;
    head_o.pc    = '0;
    if (head_valid_o) head_o = mem_q[rd_ptr_q];
  end

  assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction prefetch stage in front of decode. Runs ahead of decode with
// word-aligned reads to instruction memory, buffers in-order responses and
// hands instructions (with PC) to decode; flushes on a PC redirect.
//   clock / reset                   : clock, asynchronous active-low reset
//   mem_req_valid/ready/addr        : read request channel to memory
//   mem_resp_valid/data             : in-order read responses, no backpressure
//   redirect / redirect_pc          : flush and restart fetch at redirect_pc
//   instr_valid/ready, instr, instr_pc : instruction hand-off to decode
module fetch_prefetch
  import rv32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   inflight;
  logic          req_fire;
  logic          resp_fire;
  logic          resp_keep;
  logic [31:0]   target_pc;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Credit: words already requested plus words buffered may never exceed the
  // queue size, so every response is guaranteed a slot. Held low in reset.
  always_comb begin
    inflight      = {1'b0, outst_q} + {1'b0, fifo_count};
    mem_req_valid = reset && (inflight < (CW+1)'(DEPTH));
    req_fire      = mem_req_valid && mem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    resp_fire     = mem_resp_valid && (outst_q != '0);
    resp_keep     = resp_fire && (drop_q == '0) && !redirect;
    target_pc     = word_align(redirect_pc);
  end

  // Redirect overrides everything: responses still in flight afterwards
  // (including one requested this very cycle) belong to the old stream.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CW'(req_fire) - CW'(resp_fire);
    drop_d     = drop_q;
    if (req_fire)  fetch_pc_d = fetch_pc_q + 32'd4;
    if (resp_keep) resp_pc_d  = resp_pc_q + 32'd4;
    if (resp_fire && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (redirect) begin
      fetch_pc_d = target_pc;
      resp_pc_d  = target_pc;
      drop_d     = outst_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      resp_pc_q  <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  assign mem_req_addr     = fetch_pc_q;
  assign push_entry.instr = mem_resp_data;
  assign push_entry.pc    = resp_pc_q;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock        (clock),
    .reset        (reset),
    .push_i       (resp_keep),
    .pop_i        (instr_ready),
    .flush_i      (redirect),
    .wdata_i      (push_entry),
    .head_valid_o (instr_valid),
    .head_o       (head),
    .count_o      (fifo_count)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;

  protoNoStrayResp: assert property (@(posedge clock) disable iff (!reset)
    !(mem_resp_valid && (outst_q == '0)));

endmodule
